// File: rtl/axi_tdd_ng_sync_gen.sv
// axi_tdd_ng_sync_gen: builds the single-cycle frame-start pulse for the TDD
// frame counter. Three sources are merged into one registered pulse:
//   - sync_in: an external sync input. It is synchronized when it is
//     asynchronous, and its rising edge is the event.
//   - a programmable-period internal generator.
//   - a software request.
module axi_tdd_ng_sync_gen #(
    parameter int SYNC_COUNT_WIDTH = 64,
    parameter bit SYNC_EXT_CDC     = 1'b1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        sync_in,
    input  logic                        tdd_enable,
    input  logic                        tdd_sync_int,
    input  logic                        tdd_sync_ext,
    input  logic                        tdd_sync_soft,
    input  logic [SYNC_COUNT_WIDTH-1:0] tdd_sync_period,
    output logic                        tdd_sync,
    output logic [31:0]                 tdd_sync_cnt
);

    localparam logic [SYNC_COUNT_WIDTH-1:0] CNT_ONE = SYNC_COUNT_WIDTH'(1);

    logic                        s1_q, s1_d;
    logic                        s2_q, s2_d;
    logic                        s3_q, s3_d;
    logic [SYNC_COUNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic                        tdd_sync_q, tdd_sync_d;
    logic [31:0]                 tdd_sync_cnt_q, tdd_sync_cnt_d;

    logic ext_evt;
    logic running;
    logic int_evt;
    logic realign;

    // External path. The synchronizer keeps tracking sync_in even while the
    // block is disabled. A level that is already high at enable therefore
    // has no edge left to report.
    always_comb begin
        if (SYNC_EXT_CDC) begin
            s1_d    = sync_in;
            s2_d    = s1_q;
            s3_d    = s2_q;
            ext_evt = s2_q & ~s3_q;
        end else begin
            s1_d    = 1'b0;
            s2_d    = 1'b0;
            s3_d    = sync_in;
            ext_evt = sync_in & ~s3_q;
        end
    end

    // Internal generator. The >= compare makes a period lowered below the
    // current count wrap on the next edge instead of running to overflow.
    always_comb begin
        running = tdd_enable & tdd_sync_int & (tdd_sync_period != '0);
        int_evt = running & (period_cnt_q >= (tdd_sync_period - CNT_ONE));
        realign = tdd_enable & ((ext_evt & tdd_sync_ext) | tdd_sync_soft);
        if (!running || int_evt || realign) begin
            period_cnt_d = '0;
        end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
        end
    end

    // Merge all sources into one pulse. The emitted-pulse count lags the
    // pulse by one cycle.
    always_comb begin
        tdd_sync_d     = tdd_enable & ((ext_evt & tdd_sync_ext) | int_evt | tdd_sync_soft);
        tdd_sync_cnt_d = tdd_sync_cnt_q + 32'(tdd_sync_q);
    end

    // State registers. The reset is synchronous, so an event that is
    // pending at the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            period_cnt_q   <= '0;
            tdd_sync_q     <= 1'b0;
            tdd_sync_cnt_q <= '0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            period_cnt_q   <= period_cnt_d;
            tdd_sync_q     <= tdd_sync_d;
            tdd_sync_cnt_q <= tdd_sync_cnt_d;
        end
    end

    assign tdd_sync     = tdd_sync_q;
    assign tdd_sync_cnt = tdd_sync_cnt_q;

endmodule

// File: tb/tb_axi_tdd_ng_sync_gen.sv
// Scoreboard bench for axi_tdd_ng_sync_gen. The stimulus pushes the absolute
// cycle numbers at which tdd_sync must be seen. A monitor pops one entry on
// every pulse and flags any pulse that is unexpected or missed.
module tb_axi_tdd_ng_sync_gen;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sync_in;
    logic        tdd_enable;
    logic        tdd_sync_int;
    logic        tdd_sync_ext;
    logic        tdd_sync_soft;
    logic [63:0] tdd_sync_period;
    logic        tdd_sync;
    logic [31:0] tdd_sync_cnt;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_q[$];
    logic [31:0] exp_cnt = 32'd0;
    int          c;

    axi_tdd_ng_sync_gen #(
        .SYNC_COUNT_WIDTH(64),
        .SYNC_EXT_CDC    (1'b1)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .sync_in        (sync_in),
        .tdd_enable     (tdd_enable),
        .tdd_sync_int   (tdd_sync_int),
        .tdd_sync_ext   (tdd_sync_ext),
        .tdd_sync_soft  (tdd_sync_soft),
        .tdd_sync_period(tdd_sync_period),
        .tdd_sync       (tdd_sync),
        .tdd_sync_cnt   (tdd_sync_cnt)
    );

    always #5 clk = ~clk;

    // cyc counts rising edges; the monitor and driver work on falling edges.
    always @(posedge clk) cyc++;

    // Monitor: compare each observed pulse with the head of the queue.
    always @(negedge clk) begin
        int e;
        if (tdd_sync) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL pulse_cycle: got pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0] <= cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL pulse_missed: got no pulse at cycle %0d, expected pulse at cycle %0d", cyc, e);
        end
    end

    task automatic push(input int t);
        exp_q.push_back(t);
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn          = 1'b0;
        sync_in         = 1'b0;
        tdd_enable      = 1'b0;
        tdd_sync_int    = 1'b0;
        tdd_sync_ext    = 1'b0;
        tdd_sync_soft   = 1'b0;
        tdd_sync_period = 64'd0;
        @(negedge clk);

        // Reset held with sync_in toggling
        for (int i = 0; i < 4; i++) begin
            sync_in = ~sync_in;
            @(negedge clk);
            check("rst_sync", tdd_sync, 0);
            check("rst_cnt", tdd_sync_cnt, 0);
        end
        resetn  = 1'b1;
        sync_in = 1'b1;
        c = cyc;
        wait_cyc(c + 4);
        tdd_enable   = 1'b1;
        tdd_sync_ext = 1'b1;
        wait_cyc(c + 10);
        check("high_level_no_evt", tdd_sync_cnt, 0);
        sync_in = 1'b0;
        wait_cyc(c + 14);

        // External pulse, off-phase, 5 cycles long
        c = cyc;
        #2 sync_in = 1'b1;
        push(c + 3);
        wait_cyc(c + 5);
        sync_in = 1'b0;
        wait_cyc(c + 8);
        check("ext_cnt", tdd_sync_cnt, 1);

        // Internal period 10, then lowered to 3 while the count is 7
        c = cyc;
        tdd_sync_ext    = 1'b0;
        tdd_sync_int    = 1'b1;
        tdd_sync_period = 64'd10;
        for (int k = 1; k <= 10; k++) push(c + 10 * k);
        wait_cyc(c + 102);
        check("p10_cnt", tdd_sync_cnt, 11);
        wait_cyc(c + 107);
        tdd_sync_period = 64'd3;
        push(c + 108);
        push(c + 111);
        push(c + 114);
        wait_cyc(c + 115);
        tdd_sync_int = 1'b0;
        wait_cyc(c + 118);
        check("p3_cnt", tdd_sync_cnt, exp_cnt);

        // Realignment by external edge at count 5; soft request on int_evt
        c = cyc;
        tdd_sync_ext    = 1'b1;
        tdd_sync_int    = 1'b1;
        tdd_sync_period = 64'd8;
        push(c + 6);
        push(c + 14);
        push(c + 22);
        wait_cyc(c + 3);
        sync_in = 1'b1;
        wait_cyc(c + 6);
        sync_in = 1'b0;
        wait_cyc(c + 21);
        tdd_sync_soft = 1'b1;
        wait_cyc(c + 22);
        tdd_sync_soft = 1'b0;
        wait_cyc(c + 23);
        check("merge_cnt", tdd_sync_cnt, exp_cnt);
        push(c + 30);
        wait_cyc(c + 31);
        tdd_sync_int = 1'b0;
        wait_cyc(c + 33);

        // Disable mid-period, then restart from 0
        c = cyc;
        tdd_sync_int    = 1'b1;
        tdd_sync_period = 64'd5;
        push(c + 5);
        push(c + 10);
        wait_cyc(c + 12);
        tdd_enable = 1'b0;
        wait_cyc(c + 14);
        tdd_sync_soft = 1'b1;
        wait_cyc(c + 15);
        tdd_sync_soft = 1'b0;
        check("disable_cnt_kept", tdd_sync_cnt, exp_cnt);
        wait_cyc(c + 16);
        tdd_enable = 1'b1;
        push(c + 21);
        push(c + 26);
        wait_cyc(c + 27);
        tdd_sync_int = 1'b0;
        wait_cyc(c + 29);

        // Period 0 gives no internal pulses
        c = cyc;
        tdd_sync_int    = 1'b1;
        tdd_sync_period = 64'd0;
        wait_cyc(c + 30);
        check("p0_cnt", tdd_sync_cnt, exp_cnt);

        // Period 1 gives a pulse every cycle
        c = cyc;
        tdd_sync_period = 64'd1;
        for (int k = 1; k <= 10; k++) push(c + k);
        wait_cyc(c + 10);
        tdd_sync_int = 1'b0;
        wait_cyc(c + 13);
        check("p1_cnt", tdd_sync_cnt, exp_cnt);

        // Reset mid-operation discards a pending pulse
        c = cyc;
        tdd_sync_int    = 1'b1;
        tdd_sync_period = 64'd4;
        push(c + 4);
        wait_cyc(c + 7);
        resetn = 1'b0;
        wait_cyc(c + 8);
        check("midrst_sync", tdd_sync, 0);
        check("midrst_cnt", tdd_sync_cnt, 0);
        resetn       = 1'b1;
        tdd_sync_int = 1'b0;
        wait_cyc(c + 10);

        // Counter wrap
        c = cyc;
        force dut.tdd_sync_cnt_q = 32'hFFFF_FFFF;
        wait_cyc(c + 1);
        release dut.tdd_sync_cnt_q;
        tdd_sync_soft = 1'b1;
        push(c + 2);
        wait_cyc(c + 2);
        tdd_sync_soft = 1'b0;
        check("wrap_pre", tdd_sync_cnt, 32'hFFFF_FFFF);
        wait_cyc(c + 3);
        check("wrap_zero", tdd_sync_cnt, 0);

        wait_cyc(c + 6);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
